// File: rtl/ram_delay_pkg.sv
// Shared types and helpers for the runtime-programmable RAM delay line.
// Holds the fill FSM state type, default sizes and the depth range check.
package ram_delay_pkg;

  localparam int WIDTH_DEF     = 24;
  localparam int MAX_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  function automatic logic depth_ok(
    input int d,
    input int max_d
  );
    return (d != 0) && (d <= max_d);
  endfunction

endpackage

// File: rtl/ram_delay_mem.sv
// Simple dual-port circular buffer, synchronous read-before-write.
// One write port, one read port, no reset on storage or read register.
module ram_delay_mem #(
  parameter int WIDTH     = 24,
  parameter int MAX_DEPTH = 64,
  parameter int AW        = $clog2(MAX_DEPTH)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [MAX_DEPTH];

  // Same-address access returns the old word: both updates are non-blocking.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_delay_reader.sv
// Runtime-programmable pixel delay line with fill-tracking valid flag.
// Optional RAM_DELAY_FLUSH_EN adds a flush_i restart input.
module ram_delay_reader
  import ram_delay_pkg::*;
#(
  parameter int  WIDTH     = WIDTH_DEF,
  parameter int  MAX_DEPTH = MAX_DEPTH_DEF,
  localparam int AW        = $clog2(MAX_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
`ifdef RAM_DELAY_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW:0]      depth_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             depth_err_o
);

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      depth_q;
  logic [AW:0]      fill_cnt;
  logic             loaded;
  logic             restart;
  logic             new_ok;
  logic             re;
  logic [WIDTH-1:0] mem_q;

`ifdef RAM_DELAY_FLUSH_EN
  assign restart = flush_i || (depth_i != depth_q);
`else
  assign restart = (depth_i != depth_q);
`endif

  assign new_ok  = depth_ok(int'(depth_i), MAX_DEPTH);
  assign rd_addr = wr_ptr - depth_q[AW-1:0];
  assign re      = en_i && (state != IDLE);

  // The read register has no reset; mask it until the first real read.
  assign data_o  = loaded ? mem_q : '0;

  ram_delay_mem #(
    .WIDTH    (WIDTH),
    .MAX_DEPTH(MAX_DEPTH),
    .AW       (AW)
  ) u_mem (
    .clk_i(clk_i),
    .we   (en_i),
    .waddr(wr_ptr),
    .wdata(data_i),
    .re   (re),
    .raddr(rd_addr),
    .rdata(mem_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      depth_q     <= '0;
      fill_cnt    <= '0;
      loaded      <= 1'b0;
      valid_o     <= 1'b0;
      depth_err_o <= 1'b0;
    end else begin
      depth_err_o <= !new_ok;
      if (en_i) wr_ptr <= wr_ptr + AW'(1);
      if (re) loaded <= 1'b1;
      if (restart) begin
        depth_q  <= depth_i;
        fill_cnt <= {{AW{1'b0}}, en_i};
        valid_o  <= 1'b0;
        state    <= new_ok ? FILL : IDLE;
      end else begin
        unique case (1'b1)
          (state == FILL): begin
            if (en_i) begin
              if (fill_cnt == depth_q) begin
                state   <= RUN;
                valid_o <= 1'b1;
              end else begin
                fill_cnt <= fill_cnt + 1'b1;
              end
            end
          end
          (state == RUN): valid_o <= 1'b1;
          default: valid_o <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_delay_reader.sv
// Directed bench for ram_delay_reader: fill, gating, max depth, depth
// change, illegal depth, async reset and (if enabled) flush restart.
module tb_ram_delay_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        flush_i;
  logic [23:0] data_i;
  logic [6:0]  depth_i;
  logic [23:0] data_o;
  logic        valid_o;
  logic        depth_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] hist[$];
  int          depth_m;
  int          acc;
  int          seq;
  logic        exp_v;
  logic        exp_err;
  logic [23:0] exp_d;

  always #5 clk_i = ~clk_i;

  ram_delay_reader #(
    .WIDTH    (24),
    .MAX_DEPTH(64)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
`ifdef RAM_DELAY_FLUSH_EN
    .flush_i    (flush_i),
`endif
    .data_i     (data_i),
    .depth_i    (depth_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .depth_err_o(depth_err_o)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Restart takes effect on the next edge; the model mirrors that here.
  task automatic set_depth(input int d);
    depth_i = 7'(d);
    depth_m = d;
    acc     = 0;
    exp_v   = 1'b0;
  endtask

  task automatic step(input logic en, input logic [23:0] d);
    logic legal;
    en_i   = en;
    data_i = d;
    @(posedge clk_i);
    #1;
    legal   = (depth_m >= 1) && (depth_m <= 64);
    exp_err = !legal;
    if (en) begin
      hist.push_back(d);
      acc++;
      exp_v = legal && (acc > depth_m);
      if (exp_v) exp_d = hist[hist.size() - 1 - depth_m];
    end
    check("valid", 32'(valid_o), 32'(exp_v));
    check("depth_err", 32'(depth_err_o), 32'(exp_err));
    if (exp_v) check("data", 32'(data_o), 32'(exp_d));
    en_i = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 24'(seq));
      seq++;
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    en_i    = 1'b0;
    flush_i = 1'b0;
    data_i  = '0;
    depth_i = 7'd4;
    seq     = 1;
    exp_v   = 1'b0;
    exp_d   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_err", 32'(depth_err_o), 32'd0);
    rst_i = 1'b0;

    // Bring-up: first valid after the 5th enable, data 1
    set_depth(4);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 24'(seq));
      seq++;
      if (i == 5) check("bringup_first", 32'(data_o), 32'd1);
    end

    // Gated enable at depth 3, holds during idle cycles
    set_depth(3);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        step(1'b1, 24'(seq));
        seq++;
      end else begin
        step(1'b0, 24'hABCDEF);
      end
    end

    // Max depth with wrap and read/write collision
    set_depth(64);
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 24'(seq));
      if (i == 65) check("max_first", 32'(data_o), 32'(seq - 64));
      seq++;
    end

    // Depth change while running
    set_depth(8);
    run(12);
    set_depth(2);
    run(1);
    check("chg_invalid", 32'(valid_o), 32'd0);
    run(5);

    // Illegal depths then recovery
    set_depth(0);
    run(3);
    check("ill0_err", 32'(depth_err_o), 32'd1);
    set_depth(65);
    run(3);
    check("ill65_valid", 32'(valid_o), 32'd0);
    set_depth(5);
    run(9);

    // Async reset between edges while running
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_data", 32'(data_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    #2;
    rst_i = 1'b0;
    hist.delete();
    set_depth(5);
    run(9);

`ifdef RAM_DELAY_FLUSH_EN
    // Flush restarts the fill at the same depth
    flush_i = 1'b1;
    set_depth(5);
    run(1);
    flush_i = 1'b0;
    check("flush_valid", 32'(valid_o), 32'd0);
    run(8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
